elevator_motion_ctrl: RTL and testbench

- Sequential car controller, directly downstream of the request-availability decoder.
- Consumes the decoder's "request above / below current floor" flags and the raw 8-floor request vector.
- Owns the registered car position (floor), which feeds back into the decoder.
- Sequences motion, arrival, door timing and per-floor request-clear pulses to the request register.

---
 rtl/elevator_motion_ctrl.sv | 151 +++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion controller: owns the car floor and sequences travel, arrival and door service.
// Defining ELEVATOR_DOOR_HOLD_EN adds a door_hold input that keeps the door open while asserted.
module elevator_motion_ctrl #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] floor_req,
  input  logic       up_available_open,
  input  logic       down_available_open,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [2:0] floor,
  output logic       door_open,
  output logic       moving,
  output logic       dir_up,
  output logic [7:0] clear_req
);

  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] ONE = TW'(1);

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN} state_e;

  state_e        r_state, w_nextState;
  logic [2:0]    r_floor, w_nextFloor;
  logic          r_dirUp, w_nextDirUp;
  logic [7:0]    r_clearReq, w_nextClearReq;
  logic [TW-1:0] r_moveTmr, w_nextMoveTmr;
  logic [TW-1:0] r_doorTmr, w_nextDoorTmr;
  logic          w_hereReq, w_upOk, w_downOk, w_pickUp, w_pickDown, w_hold;
  logic          w_goDoor, w_goUp, w_goDown;

  // Direction choice shared by IDLE, ARRIVE and door close; keeps going in dir_up when both sides wait.
  assign w_hereReq  = floor_req[r_floor];
  assign w_upOk     = up_available_open && (r_floor != 3'd7);
  assign w_downOk   = down_available_open && (r_floor != 3'd0);
  assign w_pickUp   = w_upOk && (r_dirUp || !w_downOk);
  assign w_pickDown = w_downOk && (!r_dirUp || !w_upOk);

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign w_hold = door_hold;
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_nextState    = r_state;
    w_nextFloor    = r_floor;
    w_nextDirUp    = r_dirUp;
    w_nextClearReq = 8'd0;
    w_nextMoveTmr  = r_moveTmr;
    w_nextDoorTmr  = r_doorTmr;
    w_goDoor       = 1'b0;
    w_goUp         = 1'b0;
    w_goDown       = 1'b0;

    case (r_state)
      IDLE, ARRIVE: begin
        if (w_hereReq)       w_goDoor = 1'b1;
        else if (w_pickUp)   w_goUp = 1'b1;
        else if (w_pickDown) w_goDown = 1'b1;
        else                 w_nextState = IDLE;
      end
      MOVE_UP: begin
        if (r_floor == 3'd7) begin
          w_nextState = IDLE;
        end else if (r_moveTmr == '0) begin
          w_nextFloor = r_floor + 3'd1;
          w_nextState = ARRIVE;
        end else begin
          w_nextMoveTmr = r_moveTmr - ONE;
        end
      end
      MOVE_DOWN: begin
        if (r_floor == 3'd0) begin
          w_nextState = IDLE;
        end else if (r_moveTmr == '0) begin
          w_nextFloor = r_floor - 3'd1;
          w_nextState = ARRIVE;
        end else begin
          w_nextMoveTmr = r_moveTmr - ONE;
        end
      end
      DOOR_OPEN: begin
        // A request still visible during a clear pulse is the one being cleared, not a new call.
        if (w_hereReq && (r_clearReq == 8'd0)) begin
          w_nextDoorTmr  = DOOR_LOAD;
          w_nextClearReq = 8'd1 << r_floor;
        end else if (w_hold) begin
          w_nextDoorTmr = DOOR_LOAD;
        end else if (r_doorTmr != '0) begin
          w_nextDoorTmr = r_doorTmr - ONE;
        end else if (w_pickUp) begin
          w_goUp = 1'b1;
        end else if (w_pickDown) begin
          w_goDown = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase

    if (w_goDoor) begin
      w_nextState    = DOOR_OPEN;
      w_nextDoorTmr  = DOOR_LOAD;
      w_nextClearReq = 8'd1 << r_floor;
    end
    if (w_goUp) begin
      w_nextState   = MOVE_UP;
      w_nextMoveTmr = MOVE_LOAD;
      w_nextDirUp   = 1'b1;
    end
    if (w_goDown) begin
      w_nextState   = MOVE_DOWN;
      w_nextMoveTmr = MOVE_LOAD;
      w_nextDirUp   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_floor    <= 3'd0;
      r_dirUp    <= 1'b1;
      r_clearReq <= 8'd0;
      r_moveTmr  <= '0;
      r_doorTmr  <= '0;
    end else begin
      r_state    <= w_nextState;
      r_floor    <= w_nextFloor;
      r_dirUp    <= w_nextDirUp;
      r_clearReq <= w_nextClearReq;
      r_moveTmr  <= w_nextMoveTmr;
      r_doorTmr  <= w_nextDoorTmr;
    end
  end

  assign floor     = r_floor;
  assign dir_up    = r_dirUp;
  assign clear_req = r_clearReq;
  assign moving    = (r_state == MOVE_UP) || (r_state == MOVE_DOWN);
  assign door_open = (r_state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: request-register and decoder models surround the car, and a
// scoreboard of expected floor/clear/door-close events is matched by a per-cycle monitor.
module tb_elevator_motion_ctrl;

  localparam int MOVE_CYC = 4;
  localparam int DOOR_CYC = 6;
  localparam int EV_FLOOR = 0;
  localparam int EV_CLEAR = 1;
  localparam int EV_DOOR  = 2;

  typedef struct {
    int kind;
    int value;
    int gap;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] setReq = 8'd0;
  logic       forceUp = 1'b0;
  logic       forceDn = 1'b0;
  logic [7:0] reqReg;
  logic       up_available_open, down_available_open;
  logic [2:0] floor;
  logic       door_open, moving, dir_up;
  logic [7:0] clear_req;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif

  int   vectors = 0;
  int   errors = 0;
  ev_t  sbQ[$];
  ev_t  monEv;
  int   gotVal;
  int   cyc = 0;
  int   lastEvCyc = 0;
  int   doorCnt = 0;
  logic [2:0] prevFloor = 3'd0;
  logic prevDoor = 1'b0;
  bit   monOn = 1'b0;

  always #5 clk = ~clk;

  elevator_motion_ctrl #(.MOVE_CYCLES(MOVE_CYC), .DOOR_CYCLES(DOOR_CYC)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .floor_req           (reqReg),
    .up_available_open   (up_available_open),
    .down_available_open (down_available_open),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold           (door_hold),
`endif
    .floor               (floor),
    .door_open           (door_open),
    .moving              (moving),
    .dir_up              (dir_up),
    .clear_req           (clear_req)
  );

  // Request register: new calls latch, clear pulses drop the served floor.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reqReg <= 8'd0;
    else        reqReg <= (reqReg & ~clear_req) | setReq;
  end

  assign up_available_open   = forceUp | (|(reqReg & (8'hFF << (4'(floor) + 4'd1))));
  assign down_available_open = forceDn | (|(reqReg & ~(8'hFF << floor)));

  always @(negedge clk) begin
    cyc++;
    if (monOn) begin
      vectors++;
      if (moving && door_open) begin
        errors++;
        $display("[TB] FAIL invariant_move_door got moving=%0b door_open=%0b want not both", moving, door_open);
      end
      if (floor !== prevFloor) begin
        gotVal = int'(dir_up) * 8 + int'(floor);
        vectors++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL floor_event got floor=%0d dir_up=%0b want no event", floor, dir_up);
        end else begin
          monEv = sbQ.pop_front();
          if (monEv.kind != EV_FLOOR || monEv.value != gotVal ||
              (monEv.gap >= 0 && monEv.gap != cyc - lastEvCyc)) begin
            errors++;
            $display("[TB] FAIL floor_event got kind=%0d val=%0d gap=%0d want kind=%0d val=%0d gap=%0d",
                     EV_FLOOR, gotVal, cyc - lastEvCyc, monEv.kind, monEv.value, monEv.gap);
          end
        end
        lastEvCyc = cyc;
      end
      if (clear_req !== 8'd0) begin
        gotVal = int'(clear_req);
        vectors++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL clear_event got clear_req=%02h want no event", clear_req);
        end else begin
          monEv = sbQ.pop_front();
          if (monEv.kind != EV_CLEAR || monEv.value != gotVal || door_open !== 1'b1 ||
              (monEv.gap >= 0 && monEv.gap != cyc - lastEvCyc)) begin
            errors++;
            $display("[TB] FAIL clear_event got kind=%0d val=%02h gap=%0d door=%0b want kind=%0d val=%02h gap=%0d door=1",
                     EV_CLEAR, gotVal, cyc - lastEvCyc, door_open, monEv.kind, monEv.value, monEv.gap);
          end
        end
        lastEvCyc = cyc;
      end
    end
    if (prevDoor && !door_open) begin
      if (monOn) begin
        vectors++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL door_event got open_cycles=%0d want no event", doorCnt);
        end else begin
          monEv = sbQ.pop_front();
          if (monEv.kind != EV_DOOR || monEv.value != doorCnt) begin
            errors++;
            $display("[TB] FAIL door_event got kind=%0d open_cycles=%0d want kind=%0d open_cycles=%0d",
                     EV_DOOR, doorCnt, monEv.kind, monEv.value);
          end
        end
        lastEvCyc = cyc;
      end
      doorCnt = 0;
    end
    if (door_open) doorCnt++;
    prevFloor = floor;
    prevDoor  = door_open;
  end

  task automatic pushEv(input int kind, input int value, input int gap);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    e.gap   = gap;
    sbQ.push_back(e);
  endtask

  // Expected events for a trip: one floor step per MOVE_CYC+1 cycles, then a clear and a door cycle.
  task automatic pushTrip(input int fromF, input int toF, input int firstGap);
    int step = (toF > fromF) ? 1 : -1;
    int up   = (toF > fromF) ? 1 : 0;
    int g    = firstGap;
    for (int f = fromF + step; f != toF + step; f += step) begin
      pushEv(EV_FLOOR, up * 8 + f, g);
      g = MOVE_CYC + 1;
    end
    pushEv(EV_CLEAR, 1 << toF, 1);
    pushEv(EV_DOOR, DOOR_CYC, -1);
  endtask

  task automatic pulseReq(input logic [7:0] r);
    setReq = r;
    @(negedge clk);
    setReq = 8'd0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got pending=%0d want 0", sbQ.size());
      sbQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        @(negedge clk);
        #1;
      end else begin
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulseReq(8'h80);
        n = 0;
        while (!(floor === 3'd3 && moving === 1'b1) && n < 60) begin
          @(negedge clk);
          n++;
        end
        vectors++;
        if (n >= 60) begin
          errors++;
          $display("[TB] FAIL reset_reach_floor3 got floor=%0d moving=%0b want floor=3 moving=1", floor, moving);
        end
        #2 rst_n = 1'b0;
        #1;
      end
      vectors += 5;
      if (floor !== 3'd0) begin
        errors++;
        $display("[TB] FAIL reset%0d_floor got=%0d want=0", pass, floor);
      end
      if (moving !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset%0d_moving got=%0b want=0", pass, moving);
      end
      if (door_open !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset%0d_door got=%0b want=0", pass, door_open);
      end
      if (dir_up !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset%0d_dir_up got=%0b want=1", pass, dir_up);
      end
      if (clear_req !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset%0d_clear got=%02h want=00", pass, clear_req);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_up();
    pushTrip(0, 5, -1);
    pulseReq(8'h20);
    waitDrain(200);
    vectors++;
    if (floor !== 3'd5 || moving !== 1'b0 || door_open !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_up_idle got floor=%0d moving=%0b door=%0b want floor=5 moving=0 door=0",
               floor, moving, door_open);
    end
  endtask

  task automatic test_pass_reversal();
    int n = 0;
    pushTrip(5, 2, -1);
    pulseReq(8'h04);
    waitDrain(200);
    pushTrip(2, 7, -1);
    pushTrip(7, 0, MOVE_CYC);
    pulseReq(8'h80);
    while (moving !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (moving !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reversal_start got moving=%0b want=1", moving);
    end
    pulseReq(8'h01);
    waitDrain(400);
    vectors++;
    if (floor !== 3'd0 || dir_up !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reversal_end got floor=%0d dir_up=%0b want floor=0 dir_up=0", floor, dir_up);
    end
  endtask

  task automatic test_current_floor();
    pushTrip(0, 4, -1);
    pulseReq(8'h10);
    waitDrain(200);
    pushEv(EV_CLEAR, 8'h10, -1);
    pushEv(EV_CLEAR, 8'h10, 3);
    pushEv(EV_DOOR, DOOR_CYC + 3, -1);
    pulseReq(8'h10);
    @(negedge clk);
    vectors++;
    if (door_open !== 1'b1 || moving !== 1'b0) begin
      errors++;
      $display("[TB] FAIL here_req_open got door=%0b moving=%0b want door=1 moving=0", door_open, moving);
    end
    @(negedge clk);
    pulseReq(8'h10);
    waitDrain(100);
  endtask

  task automatic test_boundary();
    pushTrip(4, 7, -1);
    pulseReq(8'h80);
    waitDrain(200);
    forceUp = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (floor !== 3'd7 || moving !== 1'b0) begin
        errors++;
        $display("[TB] FAIL top_guard got floor=%0d moving=%0b want floor=7 moving=0", floor, moving);
      end
    end
    forceUp = 1'b0;
    @(negedge clk);
    pushTrip(7, 0, -1);
    pulseReq(8'h01);
    waitDrain(200);
    forceDn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (floor !== 3'd0 || moving !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bottom_guard got floor=%0d moving=%0b want floor=0 moving=0", floor, moving);
      end
    end
    forceDn = 1'b0;
    @(negedge clk);
  endtask

`ifdef ELEVATOR_DOOR_HOLD_EN
  task automatic test_door_hold();
    pushEv(EV_CLEAR, 8'h01, -1);
    pushEv(EV_DOOR, 20 + DOOR_CYC, -1);
    pulseReq(8'h01);
    @(negedge clk);
    door_hold = 1'b1;
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (door_open !== 1'b1) begin
        errors++;
        $display("[TB] FAIL door_hold_open got=%0b want=1", door_open);
      end
    end
    door_hold = 1'b0;
    waitDrain(100);
  endtask
`endif

  initial begin
    test_reset();
    monOn = 1'b1;
    test_single_up();
    test_pass_reversal();
    test_current_floor();
    test_boundary();
`ifdef ELEVATOR_DOOR_HOLD_EN
    test_door_hold();
`endif
    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got cycle=%0d want completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
